// File: rtl/audio_filter_sequencer.sv
// Output-stage filter configuration controller: host writes land in shadow registers, and a commit
// swaps them into the active set behind a gain ramp-down / settle / ramp-up so the switch is click-free.
module audio_filter_sequencer #(
  parameter int SETTLE_SAMPLES = 256,
  parameter int RAMP_STEP      = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        sample_ce,
  input  logic        wr,
  input  logic [2:0]  addr,
  input  logic [31:0] wdata,
  input  logic [15:0] core_l_in,
  input  logic [15:0] core_r_in,
  output logic [31:0] flt_rate,
  output logic [39:0] cx,
  output logic [7:0]  cx0,
  output logic [7:0]  cx1,
  output logic [7:0]  cx2,
  output logic [23:0] cy0,
  output logic [23:0] cy1,
  output logic [23:0] cy2,
  output logic [15:0] core_l,
  output logic [15:0] core_r,
  output logic [7:0]  gain,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {MUTED, IDLE, RAMP_DOWN, LOAD, SETTLE, RAMP_UP} state_t;

  localparam int              CNT_W       = $clog2(SETTLE_SAMPLES) + 1;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_SAMPLES - 1);
  localparam logic [8:0]      STEP        = 9'(RAMP_STEP);
  localparam logic [8:0]      UNITY       = 9'd128;

  state_t             state, state_next;
  logic               pending, consume, load_en, gain_dn, gain_up, cnt_inc;
  logic [CNT_W-1:0]   settle_cnt;
  logic               commit;

  logic [31:0] sh_flt_rate;
  logic [39:0] sh_cx;
  logic [7:0]  sh_cx0, sh_cx1, sh_cx2;
  logic [23:0] sh_cy0, sh_cy1, sh_cy2;

  // Signed 16 x 9 product kept at full 25 bits, then >>>7 so gain 128 is exact pass-through.
  function automatic logic [15:0] scale(input logic [15:0] x, input logic [7:0] g);
    logic signed [24:0] xe, ge, prod, shifted;
    xe      = {{9{x[15]}}, x};
    ge      = {17'd0, g};
    prod    = xe * ge;
    shifted = prod >>> 7;
    return shifted[15:0];
  endfunction

  function automatic logic [7:0] ramp_down(input logic [7:0] g);
    logic [8:0] g9;
    g9 = {1'b0, g};
    return (g9 > STEP) ? (g - STEP[7:0]) : 8'd0;
  endfunction

  function automatic logic [7:0] ramp_up(input logic [7:0] g);
    logic [8:0] s;
    s = {1'b0, g} + STEP;
    return (s >= UNITY) ? 8'd128 : s[7:0];
  endfunction

  assign commit = wr && (addr == 3'd7);
  assign busy   = (state == RAMP_DOWN) || (state == LOAD) || (state == SETTLE) || (state == RAMP_UP);
  assign done   = (state == RAMP_UP) && (gain == 8'd128);

  always_comb begin
    state_next = state;
    consume    = 1'b0;
    load_en    = 1'b0;
    gain_dn    = 1'b0;
    gain_up    = 1'b0;
    cnt_inc    = 1'b0;
    case (state)
      MUTED:     if (pending) begin state_next = LOAD; consume = 1'b1; end
      IDLE:      if (pending) begin state_next = RAMP_DOWN; consume = 1'b1; end
      RAMP_DOWN: if (gain == 8'd0) state_next = LOAD;
                 else gain_dn = sample_ce;
      LOAD:      begin load_en = 1'b1; state_next = SETTLE; end
      SETTLE:    if (sample_ce) begin
                   cnt_inc = 1'b1;
                   if (settle_cnt == SETTLE_LAST) state_next = RAMP_UP;
                 end
      RAMP_UP:   if (gain == 8'd128) state_next = IDLE;
                 else gain_up = sample_ce;
      default:   state_next = MUTED;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= MUTED;
      pending    <= 1'b0;
      settle_cnt <= '0;
      gain       <= 8'd0;
    end else begin
      state   <= state_next;
      pending <= commit | (pending & ~consume);
      if (load_en)      settle_cnt <= '0;
      else if (cnt_inc) settle_cnt <= settle_cnt + 1'b1;
      if (gain_dn)      gain <= ramp_down(gain);
      else if (gain_up) gain <= ramp_up(gain);
    end
  end

  // Shadow bank takes host writes in any state; the active bank moves only on the LOAD clock.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sh_flt_rate <= '0; sh_cx <= '0;
      sh_cx0 <= '0; sh_cx1 <= '0; sh_cx2 <= '0;
      sh_cy0 <= '0; sh_cy1 <= '0; sh_cy2 <= '0;
      flt_rate <= '0; cx <= '0;
      cx0 <= '0; cx1 <= '0; cx2 <= '0;
      cy0 <= '0; cy1 <= '0; cy2 <= '0;
    end else begin
      if (load_en) begin
        flt_rate <= sh_flt_rate; cx <= sh_cx;
        cx0 <= sh_cx0; cx1 <= sh_cx1; cx2 <= sh_cx2;
        cy0 <= sh_cy0; cy1 <= sh_cy1; cy2 <= sh_cy2;
      end
      if (wr) begin
        case (addr)
          3'd0:    sh_flt_rate <= wdata;
          3'd1:    sh_cx[31:0] <= wdata;
          3'd2:    sh_cx[39:32] <= wdata[7:0];
          3'd3:    begin sh_cx2 <= wdata[23:16]; sh_cx1 <= wdata[15:8]; sh_cx0 <= wdata[7:0]; end
          3'd4:    sh_cy0 <= wdata[23:0];
          3'd5:    sh_cy1 <= wdata[23:0];
          3'd6:    sh_cy2 <= wdata[23:0];
          default: ;
        endcase
      end
    end
  end

  // Gain stage: one-clock registered scaling of the core samples, independent of sample_ce.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      core_l <= '0;
      core_r <= '0;
    end else begin
      core_l <= scale(core_l_in, gain);
      core_r <= scale(core_r_in, gain);
    end
  end

endmodule
